// File: rtl/top_ejecucion_multiciclo_pkg.sv
// Shared definitions for the multi-cycle execute stage: ALU operation
// codes, iterative-unit FSM state encoding and width-dependent helpers.
// Imported by the RTL and by the testbench.
package top_ejecucion_multiciclo_pkg;

    // Width of the ALU operation code as decoded by the execute stage.
    localparam int ALU_CTRL_W = 4;

    // ALU operation codes.
    localparam logic [ALU_CTRL_W-1:0] ALU_AND   = 4'b0000;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR    = 4'b0001;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADDU  = 4'b0010;
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR   = 4'b0011;
    localparam logic [ALU_CTRL_W-1:0] ALU_NOR   = 4'b0100;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUBU  = 4'b0110;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT   = 4'b0111;
    localparam logic [ALU_CTRL_W-1:0] ALU_LUI   = 4'b1000;
    localparam logic [ALU_CTRL_W-1:0] ALU_MFLO  = 4'b1001;
    localparam logic [ALU_CTRL_W-1:0] ALU_MFHI  = 4'b1010;
    localparam logic [ALU_CTRL_W-1:0] ALU_MULTU = 4'b1011;
    localparam logic [ALU_CTRL_W-1:0] ALU_DIVU  = 4'b1100;
    localparam logic [ALU_CTRL_W-1:0] ALU_LINK  = 4'b1110;

    // Iterative multiply/divide unit states.
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // Iteration counter width: must hold the value W itself.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    // Operations handled by the iterative unit; they never write a register.
    function automatic logic is_iter_op(input logic [ALU_CTRL_W-1:0] op);
        return (op == ALU_MULTU) || (op == ALU_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_iterativo.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) with HI/LO.
// Latency: W+1 stall cycles (start cycle + W iterations), HI/LO written in DONE.
// Backpressure: en_i=0 freezes FSM, counter, accumulator and HI/LO.
// Divider datapath only exists when EJECUCION_DIVISOR_EN is defined.
// Ports: clk_i/rst_ni clock and async active-low reset; en_i stage advance;
//   start_mul_i/start_div_i op requests; op_a_i/op_b_i operands;
//   hi_o/lo_o HI/LO registers; stall_o upstream stall; busy_o FSM not idle.
module mult_div_iterativo
    import top_ejecucion_multiciclo_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic         start_mul_i,
    input  logic         start_div_i,
    input  logic [W-1:0] op_a_i,
    input  logic [W-1:0] op_b_i,
    output logic [W-1:0] hi_o,
    output logic [W-1:0] lo_o,
    output logic         stall_o,
    output logic         busy_o
);

    localparam int CW = cnt_width(W);

    md_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // Upper half: partial product / remainder; lower half: multiplier / quotient.
    logic [2*W-1:0]   acc_q, acc_d;
    logic [W-1:0]     opnd_q, opnd_d;
    logic [W-1:0]     hi_q, hi_d;
    logic [W-1:0]     lo_q, lo_d;
    logic             start_div_eff;
    logic             start;

`ifdef EJECUCION_DIVISOR_EN
    logic             is_div_q, is_div_d;
    logic [W:0]       div_rem_sh;
    logic [W:0]       div_diff;
    logic             div_ge;
    logic [2*W-1:0]   div_step;

    assign start_div_eff = start_div_i;

    // Restoring step: shift the next dividend bit into the remainder and
    // subtract when it fits. A zero divisor always fits, which yields an
    // all-ones quotient and leaves the dividend as the remainder.
    assign div_rem_sh = {acc_q[2*W-1:W], acc_q[W-1]};
    assign div_diff   = div_rem_sh - {1'b0, opnd_q};
    assign div_ge     = (div_rem_sh >= {1'b0, opnd_q});
    assign div_step   = {(div_ge ? div_diff[W-1:0] : div_rem_sh[W-1:0]),
                         acc_q[W-2:0], div_ge};
`else
    logic             unused_start_div;

    assign start_div_eff    = 1'b0;
    assign unused_start_div = start_div_i;
`endif

    assign start = en_i & (start_mul_i | start_div_eff);

    // Shift-add step: conditionally add the multiplicand to the upper half,
    // then shift the whole accumulator right keeping the carry.
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_step;

    assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_step = {mul_sum, acc_q[W-1:1]};

    // FSM: state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= MD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: if (start) state_d = MD_BUSY;
            // The last iteration takes the count to zero and enters DONE.
            MD_BUSY: if (en_i && (cnt_q == CW'(1))) state_d = MD_DONE;
            // Leave unconditionally: the op still on the inputs this cycle
            // is the one just finished and must not restart.
            MD_DONE: if (en_i) state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    // FSM: outputs. Stall is raised in the start cycle itself so upstream
    // holds the instruction; it is masked during reset.
    always_comb begin
        stall_o = 1'b0;
        busy_o  = 1'b0;
        case (state_q)
            MD_IDLE: stall_o = rst_ni & start;
            MD_BUSY: begin
                stall_o = rst_ni;
                busy_o  = 1'b1;
            end
            MD_DONE: busy_o = 1'b1;
            default: ;
        endcase
    end

    // Datapath next state.
    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        opnd_d = opnd_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
`ifdef EJECUCION_DIVISOR_EN
        is_div_d = is_div_q;
`endif
        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    cnt_d  = CW'(W);
                    acc_d  = {{W{1'b0}}, op_a_i};
                    opnd_d = op_b_i;
`ifdef EJECUCION_DIVISOR_EN
                    is_div_d = start_div_eff;
`endif
                end
            end
            MD_BUSY: begin
                if (en_i) begin
                    cnt_d = cnt_q - CW'(1);
`ifdef EJECUCION_DIVISOR_EN
                    acc_d = is_div_q ? div_step : mul_step;
`else
                    acc_d = mul_step;
`endif
                end
            end
            MD_DONE: begin
                if (en_i) begin
                    hi_d = acc_q[2*W-1:W];
                    lo_d = acc_q[W-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            opnd_q <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
`ifdef EJECUCION_DIVISOR_EN
            is_div_q <= 1'b0;
`endif
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
`ifdef EJECUCION_DIVISOR_EN
            is_div_q <= is_div_d;
`endif
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/top_ejecucion_multiciclo.sv
// Execute stage: operand/destination muxes, ALU, iterative mult/div, EX/MEM reg.
// Latency: single-cycle ops 1 edge; MULTU/DIVU stall upstream for W+1 cycles.
// Backpressure: i_enable_pipeline=0 holds everything; o_stall inserts bubbles.
// Optional divider: define EJECUCION_DIVISOR_EN; otherwise DIVU is a no-op bubble.
// Ports: i_clock, i_soft_reset (async active-low); i_enable_pipeline advance;
//   i_adder_pc PC+1; i_data_A/B operands; i_extension_signo_constante immediate;
//   i_reg_rt/rd destinations; i_RegDst..i_MemtoReg control; i_ALUCtrl op;
//   o_* registered EX/MEM outputs; o_stall comb stall; o_led unit busy.
module top_ejecucion_multiciclo
    import top_ejecucion_multiciclo_pkg::*;
#(
    parameter int CANT_BITS_REGISTROS   = 32,
    parameter int CANT_REGISTROS        = 32,
    parameter int CANT_BITS_ADDR        = 11,
    parameter int CANT_BITS_ALU_CONTROL = 4
) (
    input  logic                              i_clock,
    input  logic                              i_soft_reset,
    input  logic                              i_enable_pipeline,
    input  logic [CANT_BITS_ADDR-1:0]         i_adder_pc,
    input  logic [CANT_BITS_REGISTROS-1:0]    i_data_A,
    input  logic [CANT_BITS_REGISTROS-1:0]    i_data_B,
    input  logic [CANT_BITS_REGISTROS-1:0]    i_extension_signo_constante,
    input  logic [$clog2(CANT_REGISTROS)-1:0] i_reg_rt,
    input  logic [$clog2(CANT_REGISTROS)-1:0] i_reg_rd,
    input  logic                              i_RegDst,
    input  logic                              i_RegWrite,
    input  logic                              i_ALUSrc,
    input  logic                              i_MemRead,
    input  logic                              i_MemWrite,
    input  logic                              i_MemtoReg,
    input  logic [CANT_BITS_ALU_CONTROL-1:0]  i_ALUCtrl,
    output logic                              o_RegWrite,
    output logic                              o_MemRead,
    output logic                              o_MemWrite,
    output logic                              o_MemtoReg,
    output logic [CANT_BITS_REGISTROS-1:0]    o_result,
    output logic [CANT_BITS_REGISTROS-1:0]    o_data_write_to_mem,
    output logic [$clog2(CANT_REGISTROS)-1:0] o_registro_destino,
    output logic                              o_stall,
    output logic                              o_led
);

    localparam int W = CANT_BITS_REGISTROS;
    localparam int R = $clog2(CANT_REGISTROS);

    logic [ALU_CTRL_W-1:0] alu_op;
    logic [W-1:0]          operand_b;
    logic [R-1:0]          dest;
    logic [W-1:0]          alu_result;
    logic [W-1:0]          hi;
    logic [W-1:0]          lo;
    logic                  md_stall;
    logic                  md_busy;

    assign alu_op    = ALU_CTRL_W'(i_ALUCtrl);
    assign operand_b = i_ALUSrc ? i_extension_signo_constante : i_data_B;
    assign dest      = i_RegDst ? i_reg_rd : i_reg_rt;

    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_AND:  alu_result = i_data_A & operand_b;
            ALU_OR:   alu_result = i_data_A | operand_b;
            ALU_ADDU: alu_result = i_data_A + operand_b;
            ALU_XOR:  alu_result = i_data_A ^ operand_b;
            ALU_NOR:  alu_result = ~(i_data_A | operand_b);
            ALU_SUBU: alu_result = i_data_A - operand_b;
            ALU_SLT:  alu_result = {{(W-1){1'b0}},
                                    ($signed(i_data_A) < $signed(operand_b))};
            ALU_LUI:  alu_result = operand_b << (W/2);
            ALU_MFLO: alu_result = lo;
            ALU_MFHI: alu_result = hi;
            ALU_LINK: alu_result = W'(i_adder_pc);
            default:  alu_result = '0;
        endcase
    end

    mult_div_iterativo #(
        .W (W)
    ) u_mult_div (
        .clk_i       (i_clock),
        .rst_ni      (i_soft_reset),
        .en_i        (i_enable_pipeline),
        .start_mul_i (alu_op == ALU_MULTU),
        .start_div_i (alu_op == ALU_DIVU),
        .op_a_i      (i_data_A),
        .op_b_i      (operand_b),
        .hi_o        (hi),
        .lo_o        (lo),
        .stall_o     (md_stall),
        .busy_o      (md_busy)
    );

    // EX/MEM register. MULTU/DIVU only touch HI/LO, so they always retire
    // as a bubble, as does every cycle spent stalled.
    logic         regwrite_q, regwrite_d;
    logic         memread_q,  memread_d;
    logic         memwrite_q, memwrite_d;
    logic         memtoreg_q, memtoreg_d;
    logic [W-1:0] result_q,   result_d;
    logic [W-1:0] wdata_q,    wdata_d;
    logic [R-1:0] dest_q,     dest_d;

    always_comb begin
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        memtoreg_d = memtoreg_q;
        result_d   = result_q;
        wdata_d    = wdata_q;
        dest_d     = dest_q;
        if (i_enable_pipeline) begin
            if (md_stall || is_iter_op(alu_op)) begin
                regwrite_d = 1'b0;
                memread_d  = 1'b0;
                memwrite_d = 1'b0;
                memtoreg_d = 1'b0;
                result_d   = '0;
                wdata_d    = '0;
                dest_d     = '0;
            end else begin
                regwrite_d = i_RegWrite;
                memread_d  = i_MemRead;
                memwrite_d = i_MemWrite;
                memtoreg_d = i_MemtoReg;
                result_d   = alu_result;
                wdata_d    = i_data_B;
                dest_d     = dest;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_soft_reset) begin
        if (!i_soft_reset) begin
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            result_q   <= '0;
            wdata_q    <= '0;
            dest_q     <= '0;
        end else begin
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            memtoreg_q <= memtoreg_d;
            result_q   <= result_d;
            wdata_q    <= wdata_d;
            dest_q     <= dest_d;
        end
    end

    assign o_RegWrite          = regwrite_q;
    assign o_MemRead           = memread_q;
    assign o_MemWrite          = memwrite_q;
    assign o_MemtoReg          = memtoreg_q;
    assign o_result            = result_q;
    assign o_data_write_to_mem = wdata_q;
    assign o_registro_destino  = dest_q;
    assign o_stall             = md_stall;
    assign o_led               = md_busy;

endmodule
